mux4_rr_sched: RTL and testbench

MUX4_RR_SCHED -- requirements
Module: mux4_rr_sched

---
 rtl/mux4_rr_sched.sv | 120 ++++++++++++
 tb/tb_mux4_rr_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler driving the selects of an external 8-bit 4:1 mux.
// It waits SETTLE cycles for the mux to settle, then captures f and hands it off valid/ready.
module mux4_rr_sched #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [7:0] mux_f,
  input  logic       out_ready,
  output logic       sel1,
  output logic       sel0,
  output logic [3:0] gnt,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       busy,
  output logic [7:0] xfer_cnt
);

  typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

  localparam logic [3:0] SettleInit = 4'(SETTLE - 1);

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] gnt_q, gnt_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       busy_q, busy_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] xfer_cnt_q, xfer_cnt_d;
  logic [3:0] cnt_q, cnt_d;

  logic [1:0] pick_idx;
  logic [1:0] cand;

  // Scan from the farthest candidate back to ptr so the nearest requester wins.
  always_comb begin
    pick_idx = ptr_q;
    cand     = '0;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_q + 2'(i);
      if (req[cand]) pick_idx = cand;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    gnt_d       = gnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    xfer_cnt_d  = xfer_cnt_q;
    cnt_d       = cnt_q;
    case (state_q)
      StIdle: begin
        if (req != 4'b0000) begin
          sel_d   = pick_idx;
          gnt_d   = 4'b0001 << pick_idx;
          cnt_d   = SettleInit;
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == 4'd0) begin
          out_data_d  = mux_f;
          out_valid_d = 1'b1;
          state_d     = StHold;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StHold: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          gnt_d       = 4'b0000;
          ptr_d       = sel_q + 2'd1;
          xfer_cnt_d  = xfer_cnt_q + 8'd1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      sel_q       <= '0;
      gnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ptr_q       <= '0;
      xfer_cnt_q  <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      gnt_q       <= gnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      ptr_q       <= ptr_d;
      xfer_cnt_q  <= xfer_cnt_d;
      cnt_q       <= cnt_d;
    end
  end

  assign sel1      = sel_q[1];
  assign sel0      = sel_q[0];
  assign gnt       = gnt_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Scoreboard bench for mux4_rr_sched: SETTLE=1 instance plus a SETTLE=3 instance.
module tb_mux4_rr_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       out_ready;

  logic       sel1, sel0, out_valid, busy;
  logic [3:0] gnt;
  logic [7:0] out_data, xfer_cnt, mux_f;

  logic       sel1_3, sel0_3, out_valid_3, busy_3;
  logic [3:0] gnt_3;
  logic [7:0] out_data_3, xfer_cnt_3, mux_f_3;

  always #5 clk = ~clk;

  function automatic logic [7:0] mux_val(input logic [1:0] s);
    case (s)
      2'd0:    return 8'd7;
      2'd1:    return 8'd6;
      2'd2:    return 8'd5;
      default: return 8'd2;
    endcase
  endfunction

  assign mux_f   = mux_val({sel1, sel0});
  assign mux_f_3 = mux_val({sel1_3, sel0_3});

  mux4_rr_sched #(.SETTLE(1)) u_dut (
    .clk(clk), .rst(rst), .req(req), .mux_f(mux_f), .out_ready(out_ready),
    .sel1(sel1), .sel0(sel0), .gnt(gnt), .out_data(out_data), .out_valid(out_valid),
    .busy(busy), .xfer_cnt(xfer_cnt)
  );

  mux4_rr_sched #(.SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .req(req), .mux_f(mux_f_3), .out_ready(out_ready),
    .sel1(sel1_3), .sel0(sel0_3), .gnt(gnt_3), .out_data(out_data_3), .out_valid(out_valid_3),
    .busy(busy_3), .xfer_cnt(xfer_cnt_3)
  );

  typedef struct {
    logic [1:0] idx;
    logic [7:0] data;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         failures = 0;
  logic [1:0] m_ptr;
  logic [7:0] m_cnt;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req = 4'b0000; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    m_ptr = 2'd0; m_cnt = 8'd0;
    sb_q.delete();
  endtask

  // Predict the grant for request vector r from the model pointer.
  task automatic push_exp(input logic [3:0] r);
    exp_t e;
    logic [1:0] c;
    e.idx = m_ptr;
    for (int i = 3; i >= 0; i--) begin
      c = m_ptr + 2'(i);
      if (r[c]) e.idx = c;
    end
    e.data = mux_val(e.idx);
    sb_q.push_back(e);
    m_ptr = e.idx + 2'd1;
  endtask

  task automatic pop_exp(output exp_t e);
    if (sb_q.size() == 0) begin
      e.idx = 2'd0; e.data = 8'd0;
    end else begin
      e = sb_q.pop_front();
    end
  endtask

  task automatic wait_valid(input bit use3, input bit drop_req, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
      if (drop_req) req = 4'b0000;
    end while (!(use3 ? out_valid_3 : out_valid) && cyc < 50);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if ({sel1, sel0} !== 2'b00) begin failures++; $display("FAIL reset_sel got %b exp 00", {sel1, sel0}); end
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
    checks++; if (out_data !== 8'd0) begin failures++; $display("FAIL reset_data got %0d exp 0", out_data); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (xfer_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt got %0d exp 0", xfer_cnt); end
  endtask

  task automatic test_single();
    int cyc;
    exp_t e;
    out_ready = 1'b1;
    req = 4'b0100;
    push_exp(req);
    wait_valid(1'b0, 1'b1, cyc);
    checks++; if (cyc !== 2) begin failures++; $display("FAIL single_latency got %0d exp 2", cyc); end
    checks++; if (sb_q.size() !== 1) begin failures++; $display("FAIL single_sb got %0d exp 1", sb_q.size()); end
    pop_exp(e);
    checks++; if ({sel1, sel0} !== e.idx) begin failures++; $display("FAIL single_sel got %0d exp %0d", {sel1, sel0}, e.idx); end
    checks++; if (gnt !== (4'b0001 << e.idx)) begin failures++; $display("FAIL single_gnt got %b exp 0100", gnt); end
    checks++; if (out_data !== e.data) begin failures++; $display("FAIL single_data got %0d exp %0d", out_data, e.data); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got %b exp 1", busy); end
    step();
    m_cnt++;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_valid_width got %b exp 0", out_valid); end
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL single_gnt_clr got %b exp 0000", gnt); end
    checks++; if (xfer_cnt !== m_cnt) begin failures++; $display("FAIL single_cnt got %0d exp %0d", xfer_cnt, m_cnt); end
  endtask

  task automatic test_round_robin();
    int cyc;
    exp_t e;
    apply_reset();
    out_ready = 1'b1;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) push_exp(4'b1111);
    for (int k = 0; k < 5; k++) begin
      wait_valid(1'b0, 1'b0, cyc);
      checks++; if (cyc !== ((k == 0) ? 2 : 3)) begin failures++; $display("FAIL rr_spacing[%0d] got %0d exp %0d", k, cyc, (k == 0) ? 2 : 3); end
      pop_exp(e);
      checks++; if (gnt !== (4'b0001 << e.idx)) begin failures++; $display("FAIL rr_gnt[%0d] got %b exp idx %0d", k, gnt, e.idx); end
      checks++; if (out_data !== e.data) begin failures++; $display("FAIL rr_data[%0d] got %0d exp %0d", k, out_data, e.data); end
      if (k == 4) req = 4'b0000;
      m_cnt++;
    end
    step();
    checks++; if (xfer_cnt !== m_cnt) begin failures++; $display("FAIL rr_cnt got %0d exp %0d", xfer_cnt, m_cnt); end
  endtask

  task automatic test_hold();
    int cyc;
    exp_t e;
    out_ready = 1'b1;
    req = 4'b0000;
    step(); step(); step();
    checks++; if (xfer_cnt !== m_cnt) begin failures++; $display("FAIL idle_ready_cnt got %0d exp %0d", xfer_cnt, m_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got %b exp 0", busy); end
    out_ready = 1'b0;
    req = 4'b0001;
    push_exp(req);
    wait_valid(1'b0, 1'b1, cyc);
    checks++; if (cyc !== 2) begin failures++; $display("FAIL hold_latency got %0d exp 2", cyc); end
    pop_exp(e);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== e.data || {sel1, sel0} !== e.idx || gnt !== 4'b0001) begin
        failures++;
        $display("FAIL hold_stable[%0d] got v=%b d=%0d s=%0d g=%b exp v=1 d=%0d s=%0d g=0001",
                 i, out_valid, out_data, {sel1, sel0}, gnt, e.data, e.idx);
      end
      if (i < 4) step();
    end
    out_ready = 1'b1;
    step();
    m_cnt++;
    checks++; if (out_valid !== 1'b0 || gnt !== 4'b0000) begin failures++; $display("FAIL hold_release got v=%b g=%b exp v=0 g=0000", out_valid, gnt); end
    checks++; if (xfer_cnt !== m_cnt) begin failures++; $display("FAIL hold_cnt got %0d exp %0d", xfer_cnt, m_cnt); end
    step();
    checks++; if ({sel1, sel0} !== 2'b00) begin failures++; $display("FAIL idle_sel_keep got %b exp 00", {sel1, sel0}); end
    req = 4'b1111;
    push_exp(req);
    wait_valid(1'b0, 1'b1, cyc);
    pop_exp(e);
    checks++; if (gnt !== 4'b0010 || e.idx !== 2'd1) begin failures++; $display("FAIL hold_ptr_next got %b exp 0010", gnt); end
    checks++; if (out_data !== 8'd6) begin failures++; $display("FAIL hold_ptr_data got %0d exp 6", out_data); end
    step();
    m_cnt++;
  endtask

  task automatic test_settle3();
    int cyc;
    exp_t e;
    apply_reset();
    out_ready = 1'b1;
    req = 4'b1000;
    push_exp(req);
    wait_valid(1'b1, 1'b1, cyc);
    checks++; if (cyc !== 4) begin failures++; $display("FAIL settle3_latency got %0d exp 4", cyc); end
    pop_exp(e);
    checks++; if (out_data_3 !== e.data) begin failures++; $display("FAIL settle3_data got %0d exp %0d", out_data_3, e.data); end
    checks++; if (gnt_3 !== 4'b1000 || {sel1_3, sel0_3} !== e.idx) begin failures++; $display("FAIL settle3_gnt got %b exp 1000", gnt_3); end
    step();
    checks++; if (out_valid_3 !== 1'b0 || xfer_cnt_3 !== 8'd1) begin failures++; $display("FAIL settle3_done got v=%b c=%0d exp v=0 c=1", out_valid_3, xfer_cnt_3); end
  endtask

  task automatic test_reset_abort();
    int cyc;
    exp_t e;
    apply_reset();
    out_ready = 1'b0;
    req = 4'b0100;
    push_exp(req);
    wait_valid(1'b0, 1'b1, cyc);
    pop_exp(e);
    checks++; if (out_data !== e.data) begin failures++; $display("FAIL abort_pre_data got %0d exp %0d", out_data, e.data); end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_ptr = 2'd0;
    checks++;
    if ({sel1, sel0} !== 2'b00 || gnt !== 4'b0000 || out_data !== 8'd0 || out_valid !== 1'b0 ||
        busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_outputs got s=%b g=%b d=%0d v=%b b=%b exp all 0",
               {sel1, sel0}, gnt, out_data, out_valid, busy);
    end
    checks++; if (xfer_cnt !== 8'd0) begin failures++; $display("FAIL abort_cnt got %0d exp 0", xfer_cnt); end
    out_ready = 1'b1;
    req = 4'b1111;
    push_exp(req);
    wait_valid(1'b0, 1'b1, cyc);
    pop_exp(e);
    checks++; if (gnt !== 4'b0001 || out_data !== e.data) begin failures++; $display("FAIL abort_next got g=%b d=%0d exp g=0001 d=%0d", gnt, out_data, e.data); end
    step();
  endtask

  task automatic test_wrap();
    int n;
    int guard;
    apply_reset();
    req = 4'b0001;
    out_ready = 1'b1;
    n = 0;
    guard = 0;
    while (n < 256 && guard < 2000) begin
      step();
      guard++;
      if (out_valid) begin
        n++;
        if (n == 256) begin
          req = 4'b0000;
          checks++; if (xfer_cnt !== 8'd255) begin failures++; $display("FAIL wrap_pre got %0d exp 255", xfer_cnt); end
        end
      end
    end
    checks++; if (n !== 256) begin failures++; $display("FAIL wrap_xfers got %0d exp 256", n); end
    step();
    checks++; if (xfer_cnt !== 8'd0) begin failures++; $display("FAIL wrap_cnt got %0d exp 0", xfer_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_settle3();
    test_reset_abort();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
